// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types, constants and load extraction helpers for the writeback stage
package wb_pkg;

    localparam int XLEN = 32;

    // Load length encoding as presented on mem_length; the unlisted codes are illegal.
    typedef enum logic [2:0] {
        LEN_LB  = 3'b000,
        LEN_LH  = 3'b001,
        LEN_LW  = 3'b010,
        LEN_LBU = 3'b100,
        LEN_LHU = 3'b101
    } load_len_e;

    // Arbiter outcome for the current cycle.
    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_MEM  = 2'd1,
        WIN_ALU  = 2'd2
    } win_e;

    typedef struct packed {
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    // Pick the addressed byte/half out of the aligned word and extend it.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] data,
                                                    input logic [2:0]      len,
                                                    input logic [1:0]      off);
        logic [7:0]  b;
        logic [15:0] h;
        b = data[{off, 3'b000} +: 8];
        h = data[{off[1], 4'b0000} +: 16];
        case (len)
            LEN_LB:  return {{(XLEN-8){b[7]}}, b};
            LEN_LBU: return {{(XLEN-8){1'b0}}, b};
            LEN_LH:  return {{(XLEN-16){h[15]}}, h};
            LEN_LHU: return {{(XLEN-16){1'b0}}, h};
            LEN_LW:  return data;
            default: return '0;
        endcase
    endfunction

    // Misaligned half/word or an unlisted length code.
    function automatic logic load_error(input logic [2:0] len, input logic [1:0] off);
        case (len)
            LEN_LB, LEN_LBU: return 1'b0;
            LEN_LH, LEN_LHU: return off[0];
            LEN_LW:          return off != 2'b00;
            default:         return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/wb_if.sv
// rtl/wb_if.sv - ALU result and memory load-return handshake bundle
// Ports (slave = writeback side):
//   alu_valid/alu_rd_addr/alu_data in, alu_ready out
//   mem_valid/mem_rd_addr/mem_data/mem_length/mem_byte_off in, mem_ready out
interface wb_if import wb_pkg::*; ;

    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd_addr;
    logic [XLEN-1:0] alu_data;

    logic            mem_valid;
    logic            mem_ready;
    logic [4:0]      mem_rd_addr;
    logic [XLEN-1:0] mem_data;
    logic [2:0]      mem_length;
    logic [1:0]      mem_byte_off;

    modport master (
        output alu_valid, alu_rd_addr, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd_addr, mem_data, mem_length, mem_byte_off,
        input  mem_ready
    );

    modport slave (
        input  alu_valid, alu_rd_addr, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd_addr, mem_data, mem_length, mem_byte_off,
        output mem_ready
    );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of wb_entry_t with wrap-around pointers
// Ports: clk, rst (async high), push/push_data, pop/pop_data (head, first-word-through), full, empty
module wb_fifo import wb_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output wb_entry_t pop_data,
    output logic      full,
    output logic      empty
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t   mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop_data = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - writeback stage: arbitrates ALU results and load returns onto the RF write port
// Ports: clk, rst (async high); bus (wb_if.slave: ALU and load handshakes);
//   rf_we/rf_rd_addr/rf_rd_data registered RF write; wb_done retire pulse; wb_err load error pulse.
// WB_BYPASS_EN defined: adds byp_valid/byp_addr/byp_data, the unregistered winner of this cycle.
module wb_unit import wb_pkg::*; #(
    parameter int ALU_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic            clk,
    input  logic            rst,
    wb_if.slave             bus,
    output logic            rf_we,
    output logic [4:0]      rf_rd_addr,
    output logic [XLEN-1:0] rf_rd_data,
    output logic            wb_done,
    output logic            wb_err
`ifdef WB_BYPASS_EN
    ,
    output logic            byp_valid,
    output logic [4:0]      byp_addr,
    output logic [XLEN-1:0] byp_data
`endif
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            force_alu;
    wb_entry_t       alu_entry;
    wb_entry_t       head;
    logic [CW-1:0]   starve_cnt;
    win_e            win;
    logic            w_valid;
    logic            w_err;
    logic            w_write;
    logic [4:0]      w_addr;
    logic [XLEN-1:0] w_data;

    assign alu_entry.rd_addr = bus.alu_rd_addr;
    assign alu_entry.data    = bus.alu_data;

    // Loads win by default; once they have won STARVE_LIMIT times in a row over a
    // waiting ALU result, the FIFO head is forced out and loads are back-pressured.
    assign force_alu     = (starve_cnt == CW'(STARVE_LIMIT)) && !fifo_empty;
    assign bus.mem_ready = !rst && !force_alu;
    assign bus.alu_ready = !rst && !fifo_full;
    assign push          = bus.alu_valid && bus.alu_ready;
    assign pop           = (win == WIN_ALU);

    wb_fifo #(.DEPTH(ALU_FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (alu_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        win = WIN_NONE;
        if (force_alu)          win = WIN_ALU;
        else if (bus.mem_valid) win = WIN_MEM;
        else if (!fifo_empty)   win = WIN_ALU;
    end

    always_comb begin
        w_addr = '0;
        w_data = '0;
        w_err  = 1'b0;
        case (win)
            WIN_MEM: begin
                w_addr = bus.mem_rd_addr;
                w_data = load_extend(bus.mem_data, bus.mem_length, bus.mem_byte_off);
                w_err  = load_error(bus.mem_length, bus.mem_byte_off);
            end
            WIN_ALU: begin
                w_addr = head.rd_addr;
                w_data = head.data;
            end
            default: ;
        endcase
    end

    assign w_valid = (win != WIN_NONE);
    // x0 and errored loads retire without touching the register file.
    assign w_write = w_valid && !w_err && (w_addr != 5'd0);

`ifdef WB_BYPASS_EN
    assign byp_valid = w_write;
    assign byp_addr  = w_addr;
    assign byp_data  = w_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_rd_addr <= '0;
            rf_rd_data <= '0;
            wb_done    <= 1'b0;
            wb_err     <= 1'b0;
            starve_cnt <= '0;
        end else begin
            rf_we   <= w_write;
            wb_done <= w_valid;
            wb_err  <= w_valid && w_err;
            if (w_valid) begin
                rf_rd_addr <= w_addr;
                rf_rd_data <= w_data;
            end
            if ((win == WIN_MEM) && !fifo_empty) starve_cnt <= starve_cnt + 1'b1;
            else                                 starve_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_wb_unit.sv
// tb/tb_wb_unit.sv - self-checking bench for wb_unit with a queue-based reference model
module tb_wb_unit;
    import wb_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rf_we;
    logic [4:0]      rf_rd_addr;
    logic [XLEN-1:0] rf_rd_data;
    logic            wb_done;
    logic            wb_err;
`ifdef WB_BYPASS_EN
    logic            byp_valid;
    logic [4:0]      byp_addr;
    logic [XLEN-1:0] byp_data;
`endif

    wb_if bus ();

    wb_unit #(.ALU_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .rf_we      (rf_we),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .wb_done    (wb_done),
        .wb_err     (wb_err)
`ifdef WB_BYPASS_EN
        ,
        .byp_valid  (byp_valid),
        .byp_addr   (byp_addr),
        .byp_data   (byp_data)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } m_ent_t;

    m_ent_t m_q[$];
    int     m_cnt = 0;

    function automatic logic [31:0] m_extend(input logic [31:0] d, input int len, input int off);
        longint v;
        case (len)
            0, 4:    v = (d >> (8 * off)) % 32'd256;
            1, 5:    v = (d >> (16 * (off / 2))) % 32'd65536;
            2:       v = d;
            default: v = 0;
        endcase
        if (len == 0 && v >= 128)   v = v - 256;
        if (len == 1 && v >= 32768) v = v - 65536;
        return v[31:0];
    endfunction

    function automatic bit m_err(input int len, input int off);
        case (len)
            0, 4:    return 1'b0;
            1, 5:    return (off % 2) != 0;
            2:       return off != 0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic idle_inputs();
        bus.alu_valid    = 1'b0;
        bus.alu_rd_addr  = '0;
        bus.alu_data     = '0;
        bus.mem_valid    = 1'b0;
        bus.mem_rd_addr  = '0;
        bus.mem_data     = '0;
        bus.mem_length   = 3'b010;
        bus.mem_byte_off = '0;
    endtask

    task automatic set_load(input logic [4:0] a, input logic [31:0] d, input logic [2:0] len,
                            input logic [1:0] off);
        bus.mem_valid    = 1'b1;
        bus.mem_rd_addr  = a;
        bus.mem_data     = d;
        bus.mem_length   = len;
        bus.mem_byte_off = off;
    endtask

    // One clock: check handshakes against the model, predict the winner, advance, check RF outputs.
    task automatic step();
        int          sz;
        int          win;
        bit          exp_ar;
        bit          exp_mr;
        bit          forced;
        bit          do_push;
        bit          werr;
        bit          exp_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        m_ent_t      e;
        #1;
        sz     = m_q.size();
        exp_ar = sz < DEPTH;
        forced = (m_cnt == LIMIT) && (sz > 0);
        exp_mr = !forced;
        checks++;
        if (bus.alu_ready !== exp_ar) begin
            errors++;
            $display("FAIL alu_ready got %0b exp %0b t=%0t", bus.alu_ready, exp_ar, $time);
        end
        checks++;
        if (bus.mem_ready !== exp_mr) begin
            errors++;
            $display("FAIL mem_ready got %0b exp %0b t=%0t", bus.mem_ready, exp_mr, $time);
        end
        do_push = bus.alu_valid && exp_ar;
        win     = forced ? 2 : (bus.mem_valid ? 1 : (sz > 0 ? 2 : 0));
        werr    = 1'b0;
        waddr   = '0;
        wdata   = '0;
        if (win == 1) begin
            waddr = bus.mem_rd_addr;
            wdata = m_extend(bus.mem_data, bus.mem_length, bus.mem_byte_off);
            werr  = m_err(bus.mem_length, bus.mem_byte_off);
        end else if (win == 2) begin
            waddr = m_q[0].a;
            wdata = m_q[0].d;
        end
        exp_we = (win != 0) && !werr && (waddr != 0);
`ifdef WB_BYPASS_EN
        checks++;
        if (byp_valid !== exp_we || (exp_we && (byp_addr !== waddr || byp_data !== wdata))) begin
            errors++;
            $display("FAIL bypass got %0b/%0d/%h exp %0b/%0d/%h", byp_valid, byp_addr, byp_data,
                     exp_we, waddr, wdata);
        end
`endif
        m_cnt = (win == 1 && sz > 0) ? m_cnt + 1 : 0;
        if (win == 2) void'(m_q.pop_front());
        if (do_push) begin
            e.a = bus.alu_rd_addr;
            e.d = bus.alu_data;
            m_q.push_back(e);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rf_we !== exp_we || wb_done !== (win != 0) || wb_err !== (win == 1 && werr)) begin
            errors++;
            $display("FAIL rf_ctrl we/done/err got %0b%0b%0b exp %0b%0b%0b t=%0t", rf_we, wb_done,
                     wb_err, exp_we, (win != 0), (win == 1 && werr), $time);
        end
        if (exp_we) begin
            checks++;
            if (rf_rd_addr !== waddr || rf_rd_data !== wdata) begin
                errors++;
                $display("FAIL rf_write got %0d/%h exp %0d/%h t=%0t", rf_rd_addr, rf_rd_data,
                         waddr, wdata, $time);
            end
        end
    endtask

    task automatic drain();
        idle_inputs();
        for (int i = 0; i < 8; i++) step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({rf_we, wb_done, wb_err} !== 3'b000 || rf_rd_addr !== 5'd0 || rf_rd_data !== 32'd0
            || bus.mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got we%0b done%0b err%0b a%0d d%h mr%0b", rf_we, wb_done,
                     wb_err, rf_rd_addr, rf_rd_data, bus.mem_ready);
        end
        rst = 1'b0;
        m_q.delete();
        m_cnt = 0;
        step();
    endtask

    task automatic test_alu_latency();
        bus.alu_valid   = 1'b1;
        bus.alu_rd_addr = 5'd5;
        bus.alu_data    = 32'h0000_1234;
        step();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL alu_lat_early rf_we got %0b exp 0", rf_we);
        end
        idle_inputs();
        step();
        checks++;
        if (rf_we !== 1'b1 || wb_done !== 1'b1 || rf_rd_addr !== 5'd5 || rf_rd_data !== 32'h1234) begin
            errors++;
            $display("FAIL alu_lat got we%0b done%0b %0d/%h exp 1 1 5/00001234", rf_we, wb_done,
                     rf_rd_addr, rf_rd_data);
        end
        step();
        checks++;
        if (wb_done !== 1'b0) begin
            errors++;
            $display("FAIL alu_done_pulse got %0b exp 0", wb_done);
        end
    endtask

    task automatic test_load_extend();
        logic [31:0] exp_d [3];
        logic [31:0] in_d  [3];
        logic [2:0]  len   [3];
        logic [1:0]  off   [3];
        exp_d = '{32'hFFFF_FF80, 32'h0000_0000, 32'hFFFF_8001};
        in_d  = '{32'h0000_80FF, 32'h0000_80FF, 32'h8001_0000};
        len   = '{3'b000, 3'b101, 3'b001};
        off   = '{2'd1, 2'd2, 2'd2};
        for (int i = 0; i < 3; i++) begin
            set_load(5'd4, in_d[i], len[i], off[i]);
            step();
            checks++;
            if (rf_we !== 1'b1 || rf_rd_data !== exp_d[i]) begin
                errors++;
                $display("FAIL load_ext%0d got we%0b %h exp 1 %h", i, rf_we, rf_rd_data, exp_d[i]);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_starve();
        int n;
        bit seen;
        drain();
        set_load(5'd7, 32'hCAFE_0001, 3'b010, 2'd0);
        bus.alu_valid   = 1'b1;
        bus.alu_rd_addr = 5'd9;
        bus.alu_data    = 32'h0000_0909;
        step();
        bus.alu_rd_addr = 5'd10;
        bus.alu_data    = 32'h0000_0A0A;
        n    = 0;
        seen = 1'b0;
        for (int g = 0; g < 12 && !seen; g++) begin
            if (g == 1) bus.alu_valid = 1'b0;
            #1;
            if (bus.mem_ready) n++;
            else seen = 1'b1;
            step();
        end
        checks++;
        if (!seen || n != LIMIT) begin
            errors++;
            $display("FAIL starve_wins got %0d (seen %0b) exp %0d", n, seen, LIMIT);
        end
        checks++;
        if (rf_we !== 1'b1 || rf_rd_addr !== 5'd9 || rf_rd_data !== 32'h0909) begin
            errors++;
            $display("FAIL starve_retire got we%0b %0d/%h exp 1 9/00000909", rf_we, rf_rd_addr,
                     rf_rd_data);
        end
        drain();
    endtask

    task automatic test_fifo_full();
        drain();
        set_load(5'd3, 32'h0000_0033, 3'b010, 2'd0);
        bus.alu_valid   = 1'b1;
        bus.alu_rd_addr = 5'd11;
        bus.alu_data    = 32'h11;
        step();
        bus.alu_rd_addr = 5'd12;
        bus.alu_data    = 32'h12;
        step();
        #1;
        checks++;
        if (bus.alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full alu_ready got %0b exp 0", bus.alu_ready);
        end
        idle_inputs();
        step();
        bus.alu_valid   = 1'b1;
        bus.alu_rd_addr = 5'd13;
        bus.alu_data    = 32'h13;
        step();
        #1;
        checks++;
        if (bus.alu_ready !== 1'b1 || rf_rd_addr !== 5'd12) begin
            errors++;
            $display("FAIL push_pop got ready%0b addr%0d exp 1 12", bus.alu_ready, rf_rd_addr);
        end
        set_load(5'd3, 32'h0000_0034, 3'b010, 2'd0);
        bus.alu_rd_addr = 5'd14;
        bus.alu_data    = 32'h14;
        step();
        #1;
        checks++;
        if (bus.alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL refill alu_ready got %0b exp 0", bus.alu_ready);
        end
        drain();
    endtask

    task automatic test_errors();
        drain();
        set_load(5'd8, 32'h1111_2222, 3'b010, 2'd2);
        step();
        checks++;
        if ({rf_we, wb_err, wb_done} !== 3'b011) begin
            errors++;
            $display("FAIL lw_misaligned we/err/done got %0b%0b%0b exp 011", rf_we, wb_err, wb_done);
        end
        set_load(5'd8, 32'h1111_2222, 3'b111, 2'd0);
        step();
        checks++;
        if ({rf_we, wb_err, wb_done} !== 3'b011) begin
            errors++;
            $display("FAIL illegal_len we/err/done got %0b%0b%0b exp 011", rf_we, wb_err, wb_done);
        end
        idle_inputs();
        bus.alu_valid   = 1'b1;
        bus.alu_rd_addr = 5'd0;
        bus.alu_data    = 32'hDEAD_BEEF;
        step();
        idle_inputs();
        step();
        checks++;
        if ({rf_we, wb_err, wb_done} !== 3'b001) begin
            errors++;
            $display("FAIL x0_write we/err/done got %0b%0b%0b exp 001", rf_we, wb_err, wb_done);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.alu_valid    = ($urandom_range(0, 99) < 50);
            bus.alu_rd_addr  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.alu_data     = $urandom;
            bus.mem_valid    = ($urandom_range(0, 99) < 65);
            bus.mem_rd_addr  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.mem_data     = $urandom;
            bus.mem_length   = 3'($urandom_range(0, 7));
            bus.mem_byte_off = 2'($urandom_range(0, 3));
            step();
        end
        drain();
    endtask

    task automatic test_reset_mid();
        drain();
        set_load(5'd6, 32'h5A5A_A5A5, 3'b010, 2'd0);
        bus.alu_valid   = 1'b1;
        bus.alu_rd_addr = 5'd21;
        bus.alu_data    = 32'h21;
        step();
        bus.alu_rd_addr = 5'd22;
        bus.alu_data    = 32'h22;
        step();
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rf_we, wb_done, wb_err} !== 3'b000 || rf_rd_addr !== 5'd0 || rf_rd_data !== 32'd0
            || bus.mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got we%0b done%0b err%0b a%0d d%h mr%0b", rf_we, wb_done,
                     wb_err, rf_rd_addr, rf_rd_data, bus.mem_ready);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_q.delete();
        m_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (rf_we !== 1'b0 || wb_done !== 1'b0) begin
                errors++;
                $display("FAIL stale_write got we%0b done%0b exp 0 0", rf_we, wb_done);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_alu_latency();
        test_load_extend();
        test_starve();
        test_fifo_full();
        test_errors();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
